// File: rtl/multiword_adder_seq.sv
// Multi-precision adder over LS-first WIDTH-bit word stream; A-B mode under MULTIWORD_ADDER_SUB_EN.
// Latency: one cycle from input accept to registered sum word; one word per cycle sustained.
// Backpressure: single output register, in_ready = !out_valid || out_ready (no bubble).
module multiword_adder_seq #(
    parameter int WIDTH  = 8,
    parameter int NWORDS = 4,
    localparam int BW    = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_last,
`ifdef MULTIWORD_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_s,
    output logic             out_last,
    output logic             out_carry,
    output logic [BW-1:0]    out_beat
);

    logic             cy;
    logic [BW-1:0]    beat;
    logic             sub_eff;
    logic             accept;
    logic             eop;
    logic             cin;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic [WIDTH:0]   rc;

`ifdef MULTIWORD_ADDER_SUB_EN
    logic sub_r;

    // Mode is taken from the first word and frozen for the rest of the operation.
    assign sub_eff = (beat == '0) ? sub : sub_r;
`else
    assign sub_eff = 1'b0;
`endif

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign eop      = in_last || (beat == BW'(NWORDS - 1));
    assign b_eff    = sub_eff ? ~in_b : in_b;
    assign cin      = (beat == '0) ? sub_eff : cy;

    always_comb begin
        rc    = '0;
        sum   = '0;
        rc[0] = cin;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i]  = in_a[i] ^ b_eff[i] ^ rc[i];
            rc[i+1] = (in_a[i] & b_eff[i]) | (rc[i] & (in_a[i] ^ b_eff[i]));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_s     <= '0;
            out_last  <= 1'b0;
            out_carry <= 1'b0;
            out_beat  <= '0;
            cy        <= 1'b0;
            beat      <= '0;
`ifdef MULTIWORD_ADDER_SUB_EN
            sub_r     <= 1'b0;
`endif
        end else if (accept) begin
            out_valid <= 1'b1;
            out_s     <= sum;
            out_beat  <= beat;
            if (eop) begin
                out_last  <= 1'b1;
                out_carry <= rc[WIDTH];
                cy        <= 1'b0;
                beat      <= '0;
`ifdef MULTIWORD_ADDER_SUB_EN
                sub_r     <= 1'b0;
`endif
            end else begin
                out_last  <= 1'b0;
                out_carry <= 1'b0;
                cy        <= rc[WIDTH];
                beat      <= beat + BW'(1);
`ifdef MULTIWORD_ADDER_SUB_EN
                sub_r     <= sub_eff;
`endif
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_multiword_adder_seq.sv
// Bench for multiword_adder_seq: operation-level big-integer model vs. streamed words.
module tb_multiword_adder_seq;
    localparam int W  = 8;
    localparam int N  = 4;
    localparam int BW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, in_last;
    logic [W-1:0]  in_a, in_b, out_s;
    logic          out_valid, out_ready, out_last, out_carry;
    logic [BW-1:0] out_beat;
`ifdef MULTIWORD_ADDER_SUB_EN
    logic          sub;
`endif

    always #5 clk = ~clk;

    multiword_adder_seq #(.WIDTH(W), .NWORDS(N)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
`ifdef MULTIWORD_ADDER_SUB_EN
        .sub(sub),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .out_s(out_s), .out_last(out_last), .out_carry(out_carry), .out_beat(out_beat)
    );

    typedef struct {
        logic [W-1:0] a, b;
        logic         last, sb;
    } in_t;

    typedef struct {
        logic [W-1:0]  s;
        logic          last, carry;
        logic [BW-1:0] beat;
    } out_t;

    in_t  in_q[$];
    out_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
        end
    endtask

    // Whole operation as integers: n words of A and B, result S = A+B or A-B mod 2^(W*n).
    task automatic add_op(input logic [63:0] A, input logic [63:0] B, input int n,
                          input bit lst, input bit sb);
        logic [63:0] m, a, b, s;
        in_t  iw;
        out_t ow;
        m = (64'd1 << (W * n)) - 64'd1;
        a = A & m;
        b = B & m;
        s = sb ? (a + ((~b) & m) + 64'd1) : (a + b);
        for (int k = 0; k < n; k++) begin
            iw.a    = W'(a >> (W * k));
            iw.b    = W'(b >> (W * k));
            iw.last = (k == n - 1) ? lst : 1'b0;
            iw.sb   = (k == 0) ? sb : 1'($urandom);
            in_q.push_back(iw);
            ow.s     = W'(s >> (W * k));
            ow.beat  = BW'(k);
            ow.last  = (k == n - 1);
            ow.carry = (k == n - 1) ? s[W * n] : 1'b0;
            exp_q.push_back(ow);
        end
    endtask

    task automatic run(input int rdy_pct, input int vld_pct, input int stall_lo);
        int   cyc = 0;
        bit   hold_chk = 0;
        bit   fire_in;
        out_t held, e;
        while (exp_q.size() > 0 && cyc < 3000) begin
            @(negedge clk);
            if (hold_chk) begin
                check_eq("hold_s", out_s, held.s);
                check_eq("hold_ctl", {out_valid, out_last, out_carry, out_beat},
                         {1'b1, held.last, held.carry, held.beat});
            end
            in_valid = (in_q.size() > 0) && ($urandom_range(99) < vld_pct);
            if (in_q.size() > 0) begin
                in_a    = in_q[0].a;
                in_b    = in_q[0].b;
                in_last = in_q[0].last;
`ifdef MULTIWORD_ADDER_SUB_EN
                sub     = in_q[0].sb;
`endif
            end else begin
                in_a    = W'($urandom);
                in_b    = W'($urandom);
                in_last = 1'($urandom);
            end
            out_ready = (cyc >= stall_lo && cyc < stall_lo + 3) ? 1'b0
                                                                : ($urandom_range(99) < rdy_pct);
            #1;
            check_eq("in_ready", in_ready, !out_valid || out_ready);
            hold_chk   = out_valid && !out_ready;
            held.s     = out_s;
            held.last  = out_last;
            held.carry = out_carry;
            held.beat  = out_beat;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("extra_out", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("out_s", out_s, e.s);
                    check_eq("out_last", out_last, e.last);
                    check_eq("out_carry", out_carry, e.carry);
                    check_eq("out_beat", out_beat, e.beat);
                end
            end
            fire_in = in_valid && in_ready;
            @(posedge clk);
            if (fire_in) in_q.delete(0);
            cyc++;
        end
        if (exp_q.size() > 0) check_eq("timeout", exp_q.size(), 0);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_out_valid"}, out_valid, 0);
        check_eq({tag, "_in_ready"}, in_ready, 1);
        check_eq({tag, "_out_s"}, out_s, 0);
        check_eq({tag, "_ctl"}, {out_last, out_carry, out_beat}, 0);
    endtask

    // Two words of a 4-word op with carries, then reset while a sum word is pending.
    task automatic reset_mid();
        @(negedge clk);
        in_valid = 1'b1; in_a = 8'hFF; in_b = 8'h01; in_last = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        in_a = 8'hFF; in_b = 8'h01;
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_state("rst_mid");
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bit sb_rnd;
        int n;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_last = 1'b0;
`ifdef MULTIWORD_ADDER_SUB_EN
        sub = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;

        add_op(64'hFF, 64'h01, 1, 1'b1, 1'b0);
        run(100, 100, -10);

        add_op(64'h00FF_FFFF, 64'h1, 4, 1'b1, 1'b0);
        run(100, 100, 2);

        add_op(64'hFFFF_FFFF, 64'h0101_0101, 4, 1'b0, 1'b0);
        add_op(64'h00FF, 64'h0001, 2, 1'b1, 1'b0);
        run(100, 100, -10);

        reset_mid();
        add_op(64'h01, 64'h01, 1, 1'b1, 1'b0);
        run(100, 100, -10);

`ifdef MULTIWORD_ADDER_SUB_EN
        add_op(64'h0100, 64'h0001, 2, 1'b1, 1'b1);
        add_op(64'h0001, 64'h0100, 2, 1'b1, 1'b1);
        run(100, 100, 1);
`endif

        for (int i = 0; i < 60; i++) begin
            n = $urandom_range(N, 1);
`ifdef MULTIWORD_ADDER_SUB_EN
            sb_rnd = 1'($urandom);
`else
            sb_rnd = 1'b0;
`endif
            add_op({$urandom, $urandom}, {$urandom, $urandom}, n,
                   (n < N) ? 1'b1 : 1'($urandom), sb_rnd);
        end
        run(60, 70, 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
